// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
// dbg_state mirrors the controller FSM (0 = RUN, 1 = MWAIT) so checkers can bind to it.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem2reg;
    logic        ex_branch_taken;
    // Memory handshake: an access is pending while me_mem_req is high; it completes in
    // the cycle me_mem_ready is high. Once waiting, only me_mem_ready is observed.
    logic        me_mem_req;
    logic        me_mem_ready;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_stall;
    logic        ex_me_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        me_wb_flush;
    logic [15:0] stall_cnt;
    logic        mem_err;
    logic        dbg_state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem2reg,
               ex_branch_taken, me_mem_req, me_mem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_me_stall,
               if_id_flush, id_ex_flush, me_wb_flush, stall_cnt, mem_err, dbg_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem2reg,
               ex_branch_taken, me_mem_req, me_mem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_me_stall,
               if_id_flush, id_ex_flush, me_wb_flush, stall_cnt, mem_err, dbg_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: memory wait > taken branch > load-use priority.
// Define PIPE_HAZARD_CTRL_TIMEOUT_EN to build in the memory-wait watchdog and sticky mem_err.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    pipe_hazard_ctrl_if.slave hz
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be within 1..65535");
    end

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout;
    logic        mem_stall;
    logic        branch_flush;
    logic        load_use;

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        mem_err_q, mem_err_d;

    always_comb begin
        timeout   = (state_q == MWAIT) && (wdog_q == 16'(MEM_TIMEOUT));
        wdog_d    = wdog_q;
        mem_err_d = mem_err_q | timeout;
        if (state_q == RUN && state_d == MWAIT) begin
            wdog_d = '0;
        end else if (state_q == MWAIT) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    assign hz.mem_err = mem_err_q;
`else
    assign timeout    = 1'b0;
    assign hz.mem_err = 1'b0;
`endif

    // The completing (or timed-out) MWAIT cycle is not a stall, so the pipe resumes with zero extra latency.
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            RUN:     mem_stall = hz.me_mem_req & ~hz.me_mem_ready;
            MWAIT:   mem_stall = ~hz.me_mem_ready & ~timeout;
            default: mem_stall = 1'b0;
        endcase
        branch_flush = ~mem_stall & hz.ex_branch_taken;
        load_use     = ~mem_stall & ~hz.ex_branch_taken & hz.ex_mem2reg & (hz.ex_rd != 5'd0) &
                       ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                        (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
    end

    // Outputs are held quiet while reset is asserted so an abandoned wait releases the pipe at once.
    always_comb begin
        hz.pc_stall    = 1'b0;
        hz.if_id_stall = 1'b0;
        hz.id_ex_stall = 1'b0;
        hz.ex_me_stall = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.me_wb_flush = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                hz.pc_stall    = 1'b1;
                hz.if_id_stall = 1'b1;
                hz.id_ex_stall = 1'b1;
                hz.ex_me_stall = 1'b1;
                hz.me_wb_flush = 1'b1;
            end else if (branch_flush) begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (load_use) begin
                hz.pc_stall    = 1'b1;
                hz.if_id_stall = 1'b1;
                hz.id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hz.me_mem_req && !hz.me_mem_ready) state_d = MWAIT;
            MWAIT:   if (hz.me_mem_ready || timeout)        state_d = RUN;
            default: state_d = RUN;
        endcase
        stall_cnt_d = stall_cnt_q;
        if (hz.pc_stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
            wdog_q      <= '0;
            mem_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
            wdog_q      <= wdog_d;
            mem_err_q   <= mem_err_d;
`endif
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.dbg_state = (state_q == MWAIT);

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, memory-wait watchdog limit in cycles, range 1..65535.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1 / rs2.
REQ-006 ex_rd  input  5  destination register of the instruction in EX.
REQ-007 ex_mem2reg  input  1  EX instruction is a load.
REQ-008 ex_branch_taken  input  1  EX resolved a taken branch or jump.
REQ-009 me_mem_req  input  1  MEM stage issues a data-memory access this cycle.
REQ-010 me_mem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_stall, if_id_stall, id_ex_stall, ex_me_stall  output  1 each  hold the PC / pipeline register.
REQ-012 if_id_flush, id_ex_flush, me_wb_flush  output  1 each  load a bubble (all control fields 0) into the register.
REQ-013 stall_cnt  output  16  saturating count of cycles with pc_stall asserted.
REQ-014 mem_err  output  1  sticky memory-timeout flag (REQ-030).

Function
REQ-015 FSM states RUN and MWAIT; state, stall_cnt and watchdog are registered; all stall/flush outputs are combinational from state and inputs.
REQ-016 mem_stall = me_mem_req and not me_mem_ready in RUN; mem_stall = not me_mem_ready in MWAIT.
REQ-017 mem_stall: pc_stall, if_id_stall, id_ex_stall, ex_me_stall = 1, me_wb_flush = 1, every other flush = 0.
REQ-018 RUN -> MWAIT when me_mem_req and not me_mem_ready; MWAIT -> RUN in the cycle me_mem_ready = 1; that cycle has no stall from memory (zero extra latency).
REQ-019 me_mem_req = 1 with me_mem_ready = 1 in RUN: no stall, state stays RUN.
REQ-020 Branch flush, no mem_stall, ex_branch_taken = 1: if_id_flush = 1, id_ex_flush = 1, all stalls 0, for exactly that cycle.
REQ-021 Load-use, no mem_stall and no branch flush: ex_mem2reg = 1, ex_rd != 0, and (id_use_rs1 and id_rs1 == ex_rd, or id_use_rs2 and id_rs2 == ex_rd).
REQ-022 Load-use response: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1; id_ex_stall, ex_me_stall, me_wb_flush = 0; one bubble per occurrence.
REQ-023 Priority mem_stall > branch flush > load-use; a suppressed lower-priority event is re-evaluated on later cycles from the held inputs.
REQ-024 ex_rd == 0 never causes a load-use stall.
REQ-025 stall_cnt increments by 1 on each rising edge with pc_stall = 1; it saturates at 0xFFFF.
REQ-026 No event: all stall and flush outputs 0.

Reset
REQ-027 rst low asynchronously forces state RUN, stall_cnt 0, watchdog 0, mem_err 0.
REQ-028 After reset, with all inputs 0, every output is 0; rst low during MWAIT abandons the wait without a completion cycle.

Configuration
REQ-029 Macro PIPE_HAZARD_CTRL_TIMEOUT_EN compiles the memory-wait watchdog in or out.
REQ-030 Macro defined:
  - 16-bit watchdog clears on entry to MWAIT and increments each MWAIT cycle.
  - When the watchdog reaches MEM_TIMEOUT, mem_err sets (sticky until reset) and the FSM returns to RUN on the next edge.
  - That same cycle is treated as ready: mem_stall = 0.
REQ-031 Macro undefined: no watchdog logic; mem_err is tied to 0; MWAIT waits indefinitely.

Verification
REQ-032 ex_mem2reg=1, ex_rd=5, id_use_rs1=1, id_rs1=5 -> one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cnt=1.
REQ-033 Same as REQ-032 but ex_rd=0 -> no stall or flush; stall_cnt stays 0.
REQ-034 me_mem_req=1, me_mem_ready low 3 cycles then high -> 3 cycles of all four stalls plus me_wb_flush; 4th cycle all 0; state back to RUN; stall_cnt=3.
REQ-035 ex_branch_taken=1 together with a load-use match -> if_id_flush=id_ex_flush=1 and pc_stall=0; with mem_stall also active, only the mem_stall pattern appears.
REQ-036 With the macro and MEM_TIMEOUT=4, me_mem_ready held 0 -> stalls end after the watchdog reaches 4; mem_err=1 and stays 1 until rst low.
REQ-037 rst pulsed low mid-MWAIT -> all outputs 0 immediately, without waiting for clk.
